// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
package mem_arb_pkg;
    typedef enum logic {OWN_INSTR, OWN_DATA} mem_owner_e;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side instr/data ports and RAM-side port of the memory arbiter.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
);
    logic                  instr_req_i;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic                  instr_gnt_o;
    logic                  instr_rvalid_o;
    logic [MEM_DATA_W-1:0] instr_rdata_o;

    logic                  data_req_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic                  data_we_i;
    logic [MEM_BE_W-1:0]   data_be_i;
    logic [MEM_DATA_W-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [MEM_DATA_W-1:0] data_rdata_o;

    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [MEM_BE_W-1:0]   mem_be_o;
    logic [MEM_DATA_W-1:0] mem_wdata_o;
    logic [MEM_DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_arb_wait_cnt.sv
// Saturating count of consecutive cycles a pending instr request has lost arbitration.
module mem_arb_wait_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With MAX_WAIT = 0 the counter sits at 0 == MAX_C, so instr always wins.
    assign sat_o = (cnt_q == MAX_C);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between instr and data ports;
// data has priority unless instr has been starved for MAX_WAIT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus
);
    logic       instr_gnt, data_gnt;
    logic       wait_sat, wait_clr;
    logic       rsp_valid_d, rsp_valid_q;
    mem_owner_e rsp_owner_d, rsp_owner_q;
    logic       instr_rvalid, data_rvalid;

    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [MEM_BE_W-1:0]   mem_be;
    logic [MEM_DATA_W-1:0] mem_wdata;

    always_comb begin
        instr_gnt = !rst_i && bus.instr_req_i && (!bus.data_req_i || wait_sat);
        data_gnt  = !rst_i && bus.data_req_i && !instr_gnt;
        wait_clr  = !bus.instr_req_i || instr_gnt;
    end

    mem_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (wait_clr),
        .inc_i (!wait_clr),
        .sat_o (wait_sat)
    );

    always_comb begin
        mem_req   = instr_gnt || data_gnt;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_wdata = '0;
        if (instr_gnt) begin
            mem_addr = bus.instr_addr_i;
            mem_be   = '1;
        end else if (data_gnt) begin
            mem_addr  = bus.data_addr_i;
            mem_we    = bus.data_we_i;
            mem_be    = bus.data_be_i;
            mem_wdata = bus.data_wdata_i;
        end
    end

    always_comb begin
        rsp_valid_d = mem_req;
        rsp_owner_d = data_gnt ? OWN_DATA : OWN_INSTR;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_owner_q <= OWN_INSTR;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // A response still in flight when reset hits is suppressed during the reset cycle.
    always_comb begin
        instr_rvalid = !rst_i && rsp_valid_q && (rsp_owner_q == OWN_INSTR);
        data_rvalid  = !rst_i && rsp_valid_q && (rsp_owner_q == OWN_DATA);
    end

    assign bus.instr_gnt_o    = instr_gnt;
    assign bus.data_gnt_o     = data_gnt;
    assign bus.mem_req_o      = mem_req;
    assign bus.mem_addr_o     = mem_addr;
    assign bus.mem_we_o       = mem_we;
    assign bus.mem_be_o       = mem_be;
    assign bus.mem_wdata_o    = mem_wdata;
    assign bus.instr_rvalid_o = instr_rvalid;
    assign bus.data_rvalid_o  = data_rvalid;
    assign bus.instr_rdata_o  = instr_rvalid ? bus.mem_rdata_i : '0;
    assign bus.data_rdata_o   = data_rvalid ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a RAM model and a response scoreboard.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_WIDTH = 16;
    localparam int MAX_WAIT   = 4;

    typedef struct {
        mem_owner_e  own;
        logic [31:0] data;
    } rsp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mw = 0;
    rsp_t sbq[$];
    logic [31:0] ram [16384];

    mem_port_arbiter_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Read-first RAM; drives garbage when not accessed so ungated rdata shows up.
    always @(posedge clk_i) begin
        if (bus.mem_req_o) begin
            bus.mem_rdata_i <= ram[bus.mem_addr_o[15:2]];
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_be_o[b]) ram[bus.mem_addr_o[15:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
                end
            end
        end else begin
            bus.mem_rdata_i <= 32'hBAD0_BAD0;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        return (a == 16'h0080) ? 32'h0000_0013 : {16'hC0DE, 2'b00, a[15:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit ireq, input logic [15:0] ia,
                        input bit dreq, input logic [15:0] da, input bit we,
                        input logic [3:0] be, input logic [31:0] wd);
        bit   eig, edg;
        rsp_t e;
        @(negedge clk_i);
        rst_i            = r;
        bus.instr_req_i  = ireq;
        bus.instr_addr_i = ia;
        bus.data_req_i   = dreq;
        bus.data_addr_i  = da;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_wdata_i = wd;
        #2;
        if (r) begin
            sbq.delete();
            chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
            chk("rst_data_rvalid", bus.data_rvalid_o, 0);
            chk("rst_instr_rdata", bus.instr_rdata_o, 0);
            chk("rst_data_rdata", bus.data_rdata_o, 0);
        end else if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("instr_rvalid", bus.instr_rvalid_o, e.own == OWN_INSTR);
            chk("data_rvalid", bus.data_rvalid_o, e.own == OWN_DATA);
            chk("instr_rdata", bus.instr_rdata_o, (e.own == OWN_INSTR) ? e.data : 32'h0);
            chk("data_rdata", bus.data_rdata_o, (e.own == OWN_DATA) ? e.data : 32'h0);
        end else begin
            chk("idle_instr_rvalid", bus.instr_rvalid_o, 0);
            chk("idle_data_rvalid", bus.data_rvalid_o, 0);
            chk("idle_instr_rdata", bus.instr_rdata_o, 0);
            chk("idle_data_rdata", bus.data_rdata_o, 0);
        end

        eig = !r && ireq && (!dreq || mw == MAX_WAIT);
        edg = !r && dreq && !eig;
        chk("instr_gnt", bus.instr_gnt_o, eig);
        chk("data_gnt", bus.data_gnt_o, edg);
        chk("mem_req", bus.mem_req_o, eig || edg);
        chk("mem_addr", bus.mem_addr_o, eig ? ia : (edg ? da : 16'h0));
        chk("mem_we", bus.mem_we_o, edg && we);
        chk("mem_be", bus.mem_be_o, eig ? 4'hF : (edg ? be : 4'h0));
        chk("mem_wdata", bus.mem_wdata_o, edg ? wd : 32'h0);

        if (r || !ireq || eig) mw = 0;
        else if (mw < MAX_WAIT) mw++;
        if (eig) sbq.push_back('{own: OWN_INSTR, data: exp_rd(ia)});
        if (edg) sbq.push_back('{own: OWN_DATA, data: exp_rd(da)});
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 0, 16'h0, 0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = {16'hC0DE, 2'b00, 14'(i)};
        ram[32] = 32'h0000_0013;
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_wdata_i = '0;

        // reset held with both ports requesting, then data wins first
        for (int i = 0; i < 3; i++) step(1, 1, 16'h0040, 1, 16'h2000, 0, 4'hF, 32'h0);
        step(0, 1, 16'h0040, 1, 16'h2000, 0, 4'hF, 32'h0);
        idle();
        idle();

        // single instr fetch
        step(0, 1, 16'h0080, 0, 16'h0, 0, 4'h0, 32'h0);
        idle();

        // store; response returns old word (read-first RAM)
        step(0, 0, 16'h0, 1, 16'h1000, 1, 4'b0011, 32'hDEAD_BEEF);
        idle();

        // continuous contention: D,D,D,D,I,D,D,D,D,I
        for (int k = 0; k < 10; k++)
            step(0, 1, 16'(16'h0100 + 4*k), 1, 16'(16'h3000 + 4*k), 0, 4'hF, 32'h0);
        idle();

        // alternating back-to-back
        step(0, 0, 16'h0, 1, 16'h2000, 0, 4'hF, 32'h0);
        step(0, 1, 16'h0084, 0, 16'h0, 0, 4'h0, 32'h0);
        idle();

        // reset right after a data grant; wait count must restart from 0
        step(0, 1, 16'h0200, 1, 16'h2004, 0, 4'hF, 32'h0);
        step(0, 1, 16'h0200, 1, 16'h2008, 0, 4'hF, 32'h0);
        step(1, 1, 16'h0200, 1, 16'h200C, 0, 4'hF, 32'h0);
        for (int k = 0; k < 5; k++)
            step(0, 1, 16'h0200, 1, 16'(16'h2010 + 4*k), 0, 4'hF, 32'h0);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
